// File: rtl/gear3_pkg.sv
// Shared types and constants for the gear-3 boost countdown.
package gear3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StHold
    } gear3_state_e;

    // Active-high segment patterns, bit0=a ... bit6=g, bit7=dp (always 0).
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [1:0] SEL_TENS  = 2'b10;
    localparam logic [1:0] SEL_UNITS = 2'b01;

    // Tens digit by descending comparison; avoids a divider.
    function automatic logic [3:0] tens_of(input logic [6:0] val);
        logic [3:0] t;
        logic       found;
        t     = 4'd0;
        found = 1'b0;
        for (int i = 9; i >= 1; i--) begin
            if (!found && val >= 7'(10 * i)) begin
                t     = 4'(i);
                found = 1'b1;
            end
        end
        return t;
    endfunction

    // Units digit: subtract the tens contribution found above.
    function automatic logic [3:0] units_of(input logic [6:0] val);
        return 4'(val - 7'(tens_of(val)) * 7'd10);
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// BCD digit to seven-segment pattern; codes above 9 render blank.
module seg7_digit_enc
    import gear3_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Pattern lookup.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gear3_countdown.sv
// Gear-3 boost countdown: responder side of the enable/lockout handshake.
// Counts COUNT_SEC seconds while enabled, pulses done at expiry and shows the
// remaining seconds on two multiplexed digits. Display outputs are zero when
// inactive so they can be OR-combined with other sources.
// Optional: define GEAR3_COUNTDOWN_BLINK_EN to blank the display for the second
// half of each of the final five seconds.
module gear3_countdown
    import gear3_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned COUNT_SEC = 60,
    parameter int unsigned SCAN_DIV  = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       used_i,
    output logic       done_o,
    output logic [6:0] remaining_o,
    output logic [7:0] seg_out_o,
    output logic [1:0] seg_en_o
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [6:0]    COUNT_INIT = 7'(COUNT_SEC);

    gear3_state_e  state_q;
    logic [PW-1:0] pre_q;
    logic [SW-1:0] scan_q;
    logic [1:0]    sel_q;
    logic [6:0]    rem_q;
    logic          done_q;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    en_q, en_d;

    logic [3:0]    digit;
    logic [7:0]    pattern;
    logic          disp_active;

    // Control FSM, prescaler and remaining-seconds counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pre_q   <= '0;
            rem_q   <= COUNT_INIT;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // used_i only matters here; it locks out a new boost.
                    if (enable_i && !used_i) begin
                        state_q <= StRun;
                        rem_q   <= COUNT_INIT;
                        pre_q   <= '0;
                    end
                end
                StRun: begin
                    // Abort takes priority over a coincident tick.
                    if (!enable_i) begin
                        state_q <= StIdle;
                        rem_q   <= COUNT_INIT;
                        pre_q   <= '0;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        rem_q <= rem_q - 7'd1;
                        if (rem_q == 7'd1) begin
                            state_q <= StDone;
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StHold;
                end
                StHold: begin
                    if (!enable_i) begin
                        state_q <= StIdle;
                        rem_q   <= COUNT_INIT;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Digit scan: holds on tens while idle so each run starts on tens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            sel_q  <= SEL_TENS;
        end else if (state_q == StIdle) begin
            scan_q <= '0;
            sel_q  <= SEL_TENS;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            sel_q  <= (sel_q == SEL_TENS) ? SEL_UNITS : SEL_TENS;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Next display value; blanks on the same edge the FSM leaves for idle.
    always_comb begin
        digit = (sel_q == SEL_TENS) ? tens_of(rem_q) : units_of(rem_q);
        disp_active = (state_q == StDone) ||
                      (((state_q == StRun) || (state_q == StHold)) && enable_i);
`ifdef GEAR3_COUNTDOWN_BLINK_EN
        if ((state_q == StRun) && (rem_q <= 7'd5) && (pre_q >= PW'(CLK_HZ / 2))) begin
            disp_active = 1'b0;
        end
`endif
        seg_d = disp_active ? pattern : SEG_BLANK;
        en_d  = disp_active ? sel_q : 2'b00;
    end

    seg7_digit_enc u_enc (
        .bcd_i (digit),
        .seg_o (pattern)
    );

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            en_q  <= 2'b00;
        end else begin
            seg_q <= seg_d;
            en_q  <= en_d;
        end
    end

    assign done_o      = done_q;
    assign remaining_o = rem_q;
    assign seg_out_o   = seg_q;
    assign seg_en_o    = en_q;

endmodule

// File: tb/tb_gear3_countdown.sv
// Directed bench for gear3_countdown with CLK_HZ=20, COUNT_SEC=3, SCAN_DIV=2.
// Cycle k means k rising edges after the edge that moved the FSM into RUN.
module tb_gear3_countdown;

    localparam int unsigned CLK_HZ    = 20;
    localparam int unsigned COUNT_SEC = 3;
    localparam int unsigned SCAN_DIV  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_i = 1'b0;
    logic       used_i = 1'b0;
    logic       done_o;
    logic [6:0] remaining_o;
    logic [7:0] seg_out_o;
    logic [1:0] seg_en_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gear3_countdown #(
        .CLK_HZ    (CLK_HZ),
        .COUNT_SEC (COUNT_SEC),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .used_i      (used_i),
        .done_o      (done_o),
        .remaining_o (remaining_o),
        .seg_out_o   (seg_out_o),
        .seg_en_o    (seg_en_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_i = 1'b0;
        used_i = 1'b0;
        #23;
        n_tests++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", done_o);
        end
        n_tests++;
        if (remaining_o !== 7'd3) begin
            n_fail++; $display("FAIL reset_remaining: got %0d want 3", remaining_o);
        end
        n_tests++;
        if (seg_out_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_seg_out: got %h want 00", seg_out_o);
        end
        n_tests++;
        if (seg_en_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_seg_en: got %b want 00", seg_en_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_count();
        int         done_cnt = 0;
        int         done_cyc = -1;
        logic [6:0] exp_rem;
        logic       seen_t = 1'b0;
        logic       seen_u = 1'b0;
        enable_i = 1'b1;
        step();
        for (int cyc = 1; cyc <= 66; cyc++) begin
            step();
            // Lockout raised mid-run must not disturb the count.
            if (cyc == 30) used_i = 1'b1;
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc <= 60 && (cyc % 20 == 0 || cyc % 20 == 19)) begin
                exp_rem = (cyc < 20) ? 7'd3 : (cyc < 40) ? 7'd2 : (cyc < 60) ? 7'd1 : 7'd0;
                n_tests++;
                if (remaining_o !== exp_rem) begin
                    n_fail++;
                    $display("FAIL count_remaining@%0d: got %0d want %0d", cyc, remaining_o,
                             exp_rem);
                end
            end
            if (cyc >= 63) begin
                n_tests++;
                if (seg_out_o !== 8'h3F) begin
                    n_fail++; $display("FAIL hold_seg_out@%0d: got %h want 3f", cyc, seg_out_o);
                end
                if (seg_en_o === 2'b10) seen_t = 1'b1;
                if (seg_en_o === 2'b01) seen_u = 1'b1;
            end
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 61) begin
            n_fail++;
            $display("FAIL done_pulse: got %0d pulses last@%0d want 1 pulse @61", done_cnt,
                     done_cyc);
        end
        n_tests++;
        if (!(seen_t && seen_u)) begin
            n_fail++; $display("FAIL hold_scan: got tens=%b units=%b want 1 1", seen_t, seen_u);
        end
        enable_i = 1'b0;
        step();
        n_tests++;
        if (remaining_o !== 7'd3 || seg_out_o !== 8'h00 || seg_en_o !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_exit: got rem=%0d seg=%h en=%b want 3 00 00", remaining_o,
                     seg_out_o, seg_en_o);
        end
        used_i = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        enable_i = 1'b1;
        step();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (done_o === 1'b1) done_cnt++;
        end
        n_tests++;
        if (remaining_o !== 7'd2) begin
            n_fail++; $display("FAIL abort_pre: got %0d want 2", remaining_o);
        end
        enable_i = 1'b0;
        step();
        n_tests++;
        if (remaining_o !== 7'd3 || seg_out_o !== 8'h00 || seg_en_o !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: got rem=%0d seg=%h en=%b want 3 00 00", remaining_o,
                     seg_out_o, seg_en_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (done_o === 1'b1) done_cnt++;
            step();
        end
        n_tests++;
        if (done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
        end
    endtask

    task automatic test_abort_on_tick();
        int done_cnt = 0;
        enable_i = 1'b1;
        step();
        for (int cyc = 1; cyc <= 39; cyc++) step();
        n_tests++;
        if (remaining_o !== 7'd2) begin
            n_fail++; $display("FAIL tick_abort_pre: got %0d want 2", remaining_o);
        end
        // Next edge is both a prescaler tick and the abort.
        enable_i = 1'b0;
        step();
        n_tests++;
        if (remaining_o !== 7'd3) begin
            n_fail++; $display("FAIL tick_abort_rem: got %0d want 3", remaining_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (done_o === 1'b1) done_cnt++;
            step();
        end
        n_tests++;
        if (done_cnt !== 0) begin
            n_fail++; $display("FAIL tick_abort_done: got %0d pulses want 0", done_cnt);
        end
    endtask

    task automatic test_used_lockout();
        int bad_done = 0;
        int bad_disp = 0;
        int bad_rem  = 0;
        used_i = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done_o !== 1'b0) bad_done++;
            if (seg_out_o !== 8'h00 || seg_en_o !== 2'b00) bad_disp++;
            if (remaining_o !== 7'd3) bad_rem++;
        end
        n_tests++;
        if (bad_done !== 0) begin
            n_fail++; $display("FAIL used_done: got %0d bad cycles want 0", bad_done);
        end
        n_tests++;
        if (bad_disp !== 0) begin
            n_fail++; $display("FAIL used_display: got %0d bad cycles want 0", bad_disp);
        end
        n_tests++;
        if (bad_rem !== 0) begin
            n_fail++; $display("FAIL used_remaining: got %0d bad cycles want 0", bad_rem);
        end
        enable_i = 1'b0;
        used_i = 1'b0;
        step();
    endtask

    task automatic test_scan();
        logic [1:0] exp_en  [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        logic [7:0] exp_seg [6] = '{8'h3F, 8'h3F, 8'h4F, 8'h4F, 8'h3F, 8'h3F};
        enable_i = 1'b1;
        step();
        n_tests++;
        if (seg_en_o !== 2'b00) begin
            n_fail++; $display("FAIL scan_entry: got %b want 00", seg_en_o);
        end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            n_tests++;
            if (seg_en_o !== exp_en[cyc-1] || seg_out_o !== exp_seg[cyc-1]) begin
                n_fail++;
                $display("FAIL scan@%0d: got en=%b seg=%h want en=%b seg=%h", cyc, seg_en_o,
                         seg_out_o, exp_en[cyc-1], exp_seg[cyc-1]);
            end
        end
        enable_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_run();
        enable_i = 1'b1;
        step();
        for (int cyc = 1; cyc <= 25; cyc++) step();
        n_tests++;
        if (remaining_o !== 7'd2 || seg_en_o === 2'b00) begin
            n_fail++;
            $display("FAIL midrun_pre: got rem=%0d en=%b want 2 nonzero", remaining_o, seg_en_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (done_o !== 1'b0 || remaining_o !== 7'd3 || seg_out_o !== 8'h00 ||
            seg_en_o !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: got done=%b rem=%0d seg=%h en=%b want 0 3 00 00",
                     done_o, remaining_o, seg_out_o, seg_en_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
            if (cyc == 19 || cyc == 20) begin
                n_tests++;
                if (remaining_o !== ((cyc == 19) ? 7'd3 : 7'd2)) begin
                    n_fail++;
                    $display("FAIL restart@%0d: got %0d want %0d", cyc, remaining_o,
                             (cyc == 19) ? 3 : 2);
                end
            end
        end
        enable_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_full_count();
        test_abort();
        test_abort_on_tick();
        test_used_lockout();
        test_scan();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
